// File: rtl/i2c_imu_responder_pkg.sv
// Shared definitions for the emulated IMU I2C target.
//  - i2c_state_t : byte-level protocol FSM states
//  - I2C_ACK / I2C_NACK : SDA level of the acknowledge bit
//  - DEF_DEV_ADDR : default 7-bit target address
package i2c_defs;

  localparam logic [6:0] DEF_DEV_ADDR = 7'h28;
  localparam logic       I2C_ACK      = 1'b0;
  localparam logic       I2C_NACK     = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,    // waiting for START
    ST_ADDR,    // receiving address + R/W
    ST_A_ACK,   // acknowledging our address
    ST_PTR,     // receiving register pointer
    ST_P_ACK,   // acknowledging the pointer
    ST_WR,      // receiving data bytes
    ST_W_ACK,   // acknowledging a data byte
    ST_RD,      // shifting a register byte out
    ST_M_ACK,   // sampling the master's ACK/NACK
    ST_IGNORE   // bus not for us; wait for START or STOP
  } i2c_state_t;

endpackage

// File: rtl/i2c_imu_responder_line_sync.sv
// Synchronizes the raw SCL/SDA pads into sys_clk and decodes bus events.
// Ports:
//  sys_clk, rst          clock and synchronous active-high reset
//  scl_in, sda_in        pad levels (asynchronous)
//  scl_rise, scl_fall    1-cycle pulses on synced SCL edges
//  start_det, stop_det   1-cycle pulses: SDA fall / rise while SCL is high
//  sda_sync              synced SDA level, aligned with the edge pulses
module i2c_line_sync (
  input  logic sys_clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_sync
);

  // Bit 0 carries SCL, bit 1 carries SDA.
  logic [1:0] w_pad;
  logic [1:0] r_s1;
  logic [1:0] r_s2;
  logic [1:0] r_hist;

  assign w_pad = {sda_in, scl_in};

  // Reset to the idle-bus level so leaving reset does not look like an event.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_s1   <= 2'b11;
      r_s2   <= 2'b11;
      r_hist <= 2'b11;
    end else begin
      r_s1   <= w_pad;
      r_s2   <= r_s1;
      r_hist <= r_s2;
    end
  end

  assign scl_rise  =  r_s2[0] & ~r_hist[0];
  assign scl_fall  = ~r_s2[0] &  r_hist[0];
  // SCL must be high on both samples so an SDA change near an SCL edge is not misread.
  assign start_det =  r_s2[0] &  r_hist[0] &  r_hist[1] & ~r_s2[1];
  assign stop_det  =  r_s2[0] &  r_hist[0] & ~r_hist[1] &  r_s2[1];
  assign sda_sync  =  r_s2[1];

endmodule

// File: rtl/i2c_imu_responder.sv
// I2C target emulating an IMU register map.
// Ports:
//  sys_clk, rst            clock and synchronous active-high reset
//  scl_in, sda_in          I2C pads; sda_oe=1 pulls SDA low, 0 releases it
//  host_we/addr/wdata      host preload port into the register file
//  host_rdata              registered read of regfile[host_addr]
//  wr_valid/addr/data      pulse reporting each byte committed by an I2C write
//  busy                    high from an address match until STOP or mismatch
module i2c_imu_responder
  import i2c_defs::*;
#(
  parameter logic [6:0] DEV_ADDR = DEF_DEV_ADDR,
  parameter int         REG_AW   = 7
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  input  logic              host_we,
  input  logic [REG_AW-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic [7:0]        host_rdata,
  output logic              wr_valid,
  output logic [REG_AW-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy
);

  localparam int DEPTH = 1 << REG_AW;

  logic w_scl_rise, w_scl_fall, w_start, w_stop, w_sda;

  i2c_line_sync u_sync (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_rise  (w_scl_rise),
    .scl_fall  (w_scl_fall),
    .start_det (w_start),
    .stop_det  (w_stop),
    .sda_sync  (w_sda)
  );

  i2c_state_t        r_state, w_state_next;
  logic              r_sda_oe, w_sda_oe_next;
  logic [6:0]        r_shift, w_shift_next;    // rx history / tx remaining bits
  logic [2:0]        r_bit_cnt, w_bit_cnt_next;
  logic [REG_AW-1:0] r_ptr, w_ptr_next;
  logic              r_ack_ph, w_ack_ph_next;  // 1 once the ACK low has been driven
  logic              r_ld, w_ld_next;          // next SCL fall in RD loads a new byte
  logic              r_rw, w_rw_next;
  logic              r_busy, w_busy_next;
  logic              w_i2c_we, w_i2c_wr, w_host_wr;
  logic [7:0]        w_rx_byte;
  logic [7:0]        r_rd_q;
  logic [7:0]        r_host_rdata;
  logic              r_wr_valid;
  logic [REG_AW-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;
  logic [7:0]        r_mem [0:DEPTH-1];

  assign w_rx_byte = {r_shift, w_sda};

  always_comb begin
    w_state_next   = r_state;
    w_sda_oe_next  = r_sda_oe;
    w_shift_next   = r_shift;
    w_bit_cnt_next = r_bit_cnt;
    w_ptr_next     = r_ptr;
    w_ack_ph_next  = r_ack_ph;
    w_ld_next      = r_ld;
    w_rw_next      = r_rw;
    w_busy_next    = r_busy;
    w_i2c_we       = 1'b0;
    if (w_stop) begin
      w_state_next  = ST_IDLE;
      w_sda_oe_next = 1'b0;
      w_busy_next   = 1'b0;
    end else if (w_start) begin
      w_state_next   = ST_ADDR;
      w_sda_oe_next  = 1'b0;
      w_bit_cnt_next = 3'd0;
      w_ack_ph_next  = 1'b0;
    end else begin
      case (r_state)
        ST_ADDR, ST_PTR, ST_WR: begin
          if (w_scl_rise) begin
            w_shift_next   = w_rx_byte[6:0];
            w_bit_cnt_next = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              w_ack_ph_next = 1'b0;
              if (r_state == ST_ADDR) begin
                if (w_rx_byte[7:1] == DEV_ADDR) begin
                  w_state_next = ST_A_ACK;
                  w_rw_next    = w_rx_byte[0];
                  w_busy_next  = 1'b1;
                end else begin
                  w_state_next = ST_IGNORE;
                  w_busy_next  = 1'b0;
                end
              end else if (r_state == ST_PTR) begin
                w_ptr_next   = w_rx_byte[REG_AW-1:0];
                w_state_next = ST_P_ACK;
              end else begin
                w_i2c_we     = 1'b1;
                w_state_next = ST_W_ACK;
              end
            end
          end
        end
        // First SCL fall starts the ACK bit, the second one ends it.
        ST_A_ACK, ST_P_ACK, ST_W_ACK: begin
          if (w_scl_fall) begin
            if (!r_ack_ph) begin
              w_sda_oe_next = ~I2C_ACK;
              w_ack_ph_next = 1'b1;
            end else begin
              w_bit_cnt_next = 3'd0;
              if (r_state == ST_A_ACK && r_rw) begin
                w_state_next  = ST_RD;
                w_shift_next  = r_rd_q[6:0];
                w_sda_oe_next = ~r_rd_q[7];
                w_ld_next     = 1'b0;
              end else begin
                w_sda_oe_next = 1'b0;
                w_state_next  = (r_state == ST_A_ACK) ? ST_PTR : ST_WR;
                if (r_state == ST_W_ACK) w_ptr_next = r_ptr + 1'b1;
              end
            end
          end
        end
        ST_RD: begin
          if (w_scl_fall) begin
            if (r_ld) begin
              w_shift_next  = r_rd_q[6:0];
              w_sda_oe_next = ~r_rd_q[7];
              w_ld_next     = 1'b0;
            end else begin
              w_shift_next  = {r_shift[5:0], 1'b0};
              w_sda_oe_next = ~r_shift[6];
            end
          end else if (w_scl_rise) begin
            w_bit_cnt_next = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) w_state_next = ST_M_ACK;
          end
        end
        ST_M_ACK: begin
          if (w_scl_fall) begin
            w_sda_oe_next = 1'b0;
          end else if (w_scl_rise) begin
            if (w_sda == I2C_ACK) begin
              w_ptr_next     = r_ptr + 1'b1;
              w_ld_next      = 1'b1;
              w_bit_cnt_next = 3'd0;
              w_state_next   = ST_RD;
            end else begin
              w_state_next = ST_IGNORE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_sda_oe   <= 1'b0;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_ptr      <= '0;
      r_ack_ph   <= 1'b0;
      r_ld       <= 1'b0;
      r_rw       <= 1'b0;
      r_busy     <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_sda_oe   <= w_sda_oe_next;
      r_shift    <= w_shift_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_ptr      <= w_ptr_next;
      r_ack_ph   <= w_ack_ph_next;
      r_ld       <= w_ld_next;
      r_rw       <= w_rw_next;
      r_busy     <= w_busy_next;
      r_wr_valid <= w_i2c_we;
      if (w_i2c_we) begin
        r_wr_addr <= r_ptr;
        r_wr_data <= w_rx_byte;
      end
    end
  end

  // On an address collision the I2C byte wins and the host write is dropped.
  assign w_i2c_wr  = w_i2c_we & ~rst;
  assign w_host_wr = host_we & ~(w_i2c_wr & (host_addr == r_ptr));

  always_ff @(posedge sys_clk) begin
    if (w_i2c_wr)  r_mem[r_ptr]     <= w_rx_byte;
    if (w_host_wr) r_mem[host_addr] <= host_wdata;
  end

  // The pointer is stable for several cycles before the SCL fall that loads it,
  // so a registered read is always current when the shifter needs it.
  always_ff @(posedge sys_clk) begin
    r_rd_q <= r_mem[r_ptr];
  end

  always_ff @(posedge sys_clk) begin
    if (rst) r_host_rdata <= '0;
    else     r_host_rdata <= r_mem[host_addr];
  end

  assign sda_oe     = r_sda_oe;
  assign busy       = r_busy;
  assign wr_valid   = r_wr_valid;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign host_rdata = r_host_rdata;

endmodule

// File: tb/tb_i2c_imu_responder.sv
module tb_i2c_imu_responder;

  localparam int Q = 6;   // SCL low half around the SDA change
  localparam int H = 8;   // SCL high time

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       host_we = 1'b0;
  logic [6:0] host_addr = '0;
  logic [7:0] host_wdata = '0;
  logic       sda_oe, busy, wr_valid;
  logic [7:0] host_rdata, wr_data;
  logic [6:0] wr_addr;
  logic       sda_bus;

  assign sda_bus = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  i2c_imu_responder #(.DEV_ADDR(7'h28), .REG_AW(7)) dut (
    .sys_clk    (clk),
    .rst        (rst),
    .scl_in     (m_scl),
    .sda_in     (sda_bus),
    .sda_oe     (sda_oe),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy)
  );

  int n_checks = 0;
  int n_err = 0;
  int n_wr = 0;
  int n_oe_viol = 0;
  int n_quiet_viol = 0;
  bit quiet = 1'b0;

  logic [7:0]  exp_rd[$];
  logic [14:0] exp_wr[$];

  typedef struct {
    logic [6:0] ptr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
  } vec_t;
  vec_t vecs[3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; wait_cyc(Q);
    m_scl = 1'b1; wait_cyc(H);
    m_sda = 1'b0; wait_cyc(H);
    m_scl = 1'b0; wait_cyc(Q);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wait_cyc(Q);
    m_scl = 1'b1; wait_cyc(H);
    m_sda = 1'b1; wait_cyc(H);
  endtask

  // One SCL bit. With coll set, host_we is held from before the rise until the
  // DUT reports its I2C write, so the host write overlaps the I2C commit cycle.
  task automatic bus_bit(input logic b, input bit coll, output logic s);
    s = 1'b1;
    m_sda = b; wait_cyc(Q);
    if (coll) host_we = 1'b1;
    m_scl = 1'b1;
    for (int c = 0; c < H; c++) begin
      @(negedge clk);
      if (c == H / 2) s = sda_bus;
      if (coll && wr_valid) host_we = 1'b0;
    end
    if (coll) host_we = 1'b0;
    m_scl = 1'b0; wait_cyc(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, input bit coll, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(d[i], coll && (i == 0), s);
    bus_bit(1'b1, 1'b0, ack);
  endtask

  task automatic read_byte(input logic mack, input string nm);
    logic [7:0] d;
    logic s;
    d = '0;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, 1'b0, s);
      d[i] = s;
    end
    bus_bit(mack, 1'b0, s);
    if (exp_rd.size() == 0) begin
      n_checks++; n_err++;
      $display("FAIL %s: got %0h, required no read pending", nm, d);
    end else begin
      chk(nm, 32'(d), 32'(exp_rd.pop_front()));
    end
    $display("txn i2c_read %s data=%0h", nm, d);
  endtask

  task automatic host_write(input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    @(negedge clk);
    host_we = 1'b0;
    $display("txn host_write addr=%0h data=%0h", a, d);
  endtask

  task automatic host_read(input logic [6:0] a, input logic [7:0] exp, input string nm);
    @(negedge clk);
    host_addr = a;
    @(negedge clk);
    chk(nm, 32'(host_rdata), 32'(exp));
    $display("txn host_read addr=%0h data=%0h", a, host_rdata);
  endtask

  // START, device write address, pointer byte; returns OR of the two ACK bits.
  task automatic set_ptr(input logic [6:0] p, output logic ack_or);
    logic a0, a1;
    bus_start();
    write_byte(8'h50, 1'b0, a0);
    write_byte({1'b0, p}, 1'b0, a1);
    ack_or = a0 | a1;
  endtask

  // Bus rule monitor: sda_oe must hold while SCL is high; quiet window checks.
  logic prev_scl = 1'b1;
  logic prev_oe  = 1'b0;
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (m_scl && prev_scl && (sda_oe !== prev_oe)) n_oe_viol++;
      if (quiet && (sda_oe || busy)) n_quiet_viol++;
    end
    prev_scl = m_scl;
    prev_oe  = sda_oe;
  end

  // Write scoreboard: every wr_valid pulse is matched against the queue.
  always @(negedge clk) begin
    logic [14:0] e;
    if (!rst && wr_valid) begin
      n_wr++;
      if (exp_wr.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL wr_unexpected: got addr=%0h data=%0h, required no write", wr_addr, wr_data);
      end else begin
        e = exp_wr.pop_front();
        chk("wr_commit", 32'({wr_addr, wr_data}), 32'(e));
      end
      $display("txn wr_valid addr=%0h data=%0h", wr_addr, wr_data);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ack, ack2;
    int   n0;

    vecs[0] = '{ptr: 7'h12, wdata: 8'h5A, exp_rd: 8'h5A};
    vecs[1] = '{ptr: 7'h40, wdata: 8'hFF, exp_rd: 8'hFF};
    vecs[2] = '{ptr: 7'h7E, wdata: 8'h01, exp_rd: 8'h01};

    // Reset state
    wait_cyc(4);
    chk("rst_sda_oe", 32'(sda_oe), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wr_valid", 32'(wr_valid), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_host_rdata", 32'(host_rdata), 0);
    rst = 1'b0;
    wait_cyc(4);

    // 1: pointer write, repeated START, two-byte read
    host_write(7'h00, 8'hA0);
    host_write(7'h01, 8'hA1);
    bus_start();
    write_byte(8'h50, 1'b0, ack);
    chk("t1_addr_ack", 32'(ack), 0);
    chk("t1_busy", 32'(busy), 1);
    write_byte(8'h00, 1'b0, ack);
    chk("t1_ptr_ack", 32'(ack), 0);
    bus_start();
    write_byte(8'h51, 1'b0, ack);
    chk("t1_raddr_ack", 32'(ack), 0);
    exp_rd.push_back(8'hA0);
    exp_rd.push_back(8'hA1);
    read_byte(1'b0, "t1_rd0");
    read_byte(1'b1, "t1_rd1");
    bus_stop();
    chk("t1_busy_after_stop", 32'(busy), 0);

    // 2: two-byte burst write with pointer increment
    n0 = n_wr;
    set_ptr(7'h3D, ack);
    chk("t2_hdr_ack", 32'(ack), 0);
    exp_wr.push_back({7'h3D, 8'h0C});
    write_byte(8'h0C, 1'b0, ack);
    chk("t2_d0_ack", 32'(ack), 0);
    exp_wr.push_back({7'h3E, 8'h55});
    write_byte(8'h55, 1'b0, ack);
    chk("t2_d1_ack", 32'(ack), 0);
    bus_stop();
    chk("t2_wr_count", 32'(n_wr - n0), 2);
    host_read(7'h3E, 8'h55, "t2_host_3e");

    // 3: wrong address is ignored entirely
    n0 = n_wr;
    quiet = 1'b1;
    bus_start();
    write_byte(8'h52, 1'b0, ack);
    chk("t3_addr_nack", 32'(ack), 1);
    write_byte(8'h11, 1'b0, ack);
    chk("t3_data_nack", 32'(ack), 1);
    bus_stop();
    quiet = 1'b0;
    chk("t3_quiet", 32'(n_quiet_viol), 0);
    chk("t3_no_wr", 32'(n_wr), 32'(n0));

    // Table: write one byte by I2C, read it back by I2C and by host
    foreach (vecs[k]) begin
      set_ptr(vecs[k].ptr, ack);
      exp_wr.push_back({vecs[k].ptr, vecs[k].wdata});
      write_byte(vecs[k].wdata, 1'b0, ack2);
      bus_stop();
      chk("vec_wr_acks", 32'(ack | ack2), 0);
      set_ptr(vecs[k].ptr, ack);
      bus_start();
      write_byte(8'h51, 1'b0, ack2);
      chk("vec_rd_acks", 32'(ack | ack2), 0);
      exp_rd.push_back(vecs[k].exp_rd);
      read_byte(1'b1, "vec_i2c_rd");
      bus_stop();
      host_read(vecs[k].ptr, vecs[k].exp_rd, "vec_host_rd");
    end

    // 4: burst read wraps the pointer from 0x7F to 0x00
    host_write(7'h7F, 8'h5A);
    host_write(7'h00, 8'hC3);
    set_ptr(7'h7F, ack);
    bus_start();
    write_byte(8'h51, 1'b0, ack2);
    chk("t4_acks", 32'(ack | ack2), 0);
    exp_rd.push_back(8'h5A);
    exp_rd.push_back(8'hC3);
    read_byte(1'b0, "t4_rd_7f");
    read_byte(1'b1, "t4_rd_wrap");
    bus_stop();

    // 5: STOP after four data bits aborts the byte
    n0 = n_wr;
    set_ptr(7'h20, ack);
    for (int i = 0; i < 4; i++) bus_bit(i[0], 1'b0, ack2);
    bus_stop();
    chk("t5_no_wr", 32'(n_wr), 32'(n0));
    chk("t5_busy", 32'(busy), 0);
    bus_start();
    write_byte(8'h50, 1'b0, ack);
    chk("t5_restart_ack", 32'(ack), 0);
    bus_stop();

    // 6: reset while driving SDA during a read
    host_write(7'h05, 8'h00);
    set_ptr(7'h05, ack);
    bus_start();
    write_byte(8'h51, 1'b0, ack2);
    chk("t6_acks", 32'(ack | ack2), 0);
    for (int c = 0; c < 50 && !sda_oe; c++) @(negedge clk);
    chk("t6_oe_driven", 32'(sda_oe), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_oe_after_rst", 32'(sda_oe), 0);
    rst = 1'b0;
    wait_cyc(2);
    bus_stop();

    // Same-address collision: I2C byte must win
    set_ptr(7'h10, ack);
    host_addr = 7'h10; host_wdata = 8'h44;
    exp_wr.push_back({7'h10, 8'h99});
    write_byte(8'h99, 1'b1, ack2);
    bus_stop();
    chk("t6_coll_acks", 32'(ack | ack2), 0);
    host_read(7'h10, 8'h99, "t6_same_addr");

    // Different-address overlap: both writes land
    set_ptr(7'h20, ack);
    host_addr = 7'h11; host_wdata = 8'h66;
    exp_wr.push_back({7'h20, 8'h77});
    write_byte(8'h77, 1'b1, ack2);
    bus_stop();
    host_read(7'h20, 8'h77, "t6_i2c_side");
    host_read(7'h11, 8'h66, "t6_host_side");

    wait_cyc(4);
    chk("wr_sb_empty", 32'(exp_wr.size()), 0);
    chk("rd_sb_empty", 32'(exp_rd.size()), 0);
    chk("oe_stable_scl_high", 32'(n_oe_viol), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
